keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner that generalises the fixed 4x4 scanner to ROWS x COLS keys. It adds per-key debounce, press and release events, and a small event FIFO with a valid/ready handshake. It drives one-hot row strobes, samples the column inputs, and reports debounced key state. It sits between the keypad pins and game/control logic, such as paddle control.

Parameters:
ROWS, 4, number of driven row lines (>=2)
COLS, 4, number of sensed column lines (>=2)
SCAN_DIV, 1000, clk cycles each row is held active; must be >= COLS+1
DEBOUNCE, 3, consecutive differing samples of a key required to change its debounced state (>=1)
EVT_DEPTH, 4, event FIFO depth (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
row_out  out  ROWS  one-hot row strobe, active high
col_in  in  COLS  column sense, 1 = key in active row closed; synchronised internally by a 2-flop synchroniser
key_valid  out  1  FIFO non-empty, event available
key_ready  in  1  consumer accepts the event
key_code  out  $clog2(ROWS*COLS)  code of the event at the FIFO head, row*COLS+col
key_release  out  1  0 = press event, 1 = release event (FIFO head)
pressed  out  ROWS*COLS  debounced state, bit k = key code k held
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): row index 0, dwell counter 0, row_out = one-hot bit0.
- Reset also clears: synchroniser, capture register, all debounce counters, pressed, FIFO (key_valid=0), overflow; key_code and key_release read 0.
- Dwell counter d runs 0..SCAN_DIV-1. When d wraps, the row index increments mod ROWS and row_out advances to the next one-hot value.
- Scan period is ROWS*SCAN_DIV cycles; row_out is never zero and never multi-hot.
- Capture: at d==SCAN_DIV-1, the synchronised col_in and the current row index are latched into a capture register.
- Evaluation: during d==0..COLS-1 of the following dwell, column c=d of the captured row is evaluated, one key per cycle. The key code is k = row*COLS+c.
- Per-key debounce counter cnt[k], width $clog2(DEBOUNCE+1), is updated as follows:
  - If raw==pressed[k]: cnt[k] <= 0.
  - Else if cnt[k]==DEBOUNCE-1: pressed[k] <= raw, cnt[k] <= 0, and push event {k, release = ~raw}.
  - Else: cnt[k] <= cnt[k]+1.
  - DEBOUNCE=1 means the state flips on the first differing sample.
- At most one push per cycle. Events from the same row enter the FIFO in ascending column order.
- FIFO behaviour:
  - key_valid is registered. It rises the cycle after the first push into an empty FIFO.
  - key_code and key_release hold steady while key_valid && !key_ready.
  - A pop occurs when key_valid && key_ready.
- Push on full FIFO without a pop in the same cycle: the event is dropped, overflow <= 1 (sticky until rst), and pressed is still updated.
- Push and pop in the same cycle on a full FIFO: both take effect, no overflow.
- Push and pop in the same cycle on a one-entry FIFO: the new event becomes the head next cycle and key_valid stays 1.
- FIFO pointers wrap modulo EVT_DEPTH; the count saturates at EVT_DEPTH and never exceeds it.
- Press latency: a key closed stably becomes pressed on its DEBOUNCE-th capture. The event is visible at most COLS+1 cycles after that capture.
- Multiple keys may be held simultaneously; each is debounced independently. No ghosting suppression is performed.
- Reset mid-operation clears everything immediately, including pending events. The scan restarts at row 0.

Test Plan:
Common setup: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, EVT_DEPTH=4, key_ready=1 unless stated.
- Reset then free-run: row_out=0001, key_valid=0, pressed=0. row_out reads 0010 at cycle 8, 0100 at 16, 1000 at 24, 0001 at 32.
- Hold key row1/col2 (col_in[2]=1 whenever row_out[1]=1) -> after the 3rd capture of row1: key_valid=1, key_code=6, key_release=0, pressed[6]=1. Releasing it for 3 scans -> key_code=6, key_release=1, pressed[6]=0.
- Bounce on key 6: closed 2 scans, open 1, closed 2 -> no event, pressed[6]=0. Counter reset verified.
- Hold row2 col0 and col3 together -> two events key_code=8 then 11 on consecutive FIFO entries, both key_release=0.
- key_ready=0 while generating 5 press events -> key_valid=1 with the first event held steady, overflow=1. Then key_ready=1 pops exactly 4 events in order; the 5th is lost but its pressed bit is 1.
- Assert rst asynchronously mid-dwell with key_valid=1 and pressed[6]=1 -> same-cycle key_valid=0, pressed=0, row_out=0001, overflow=0. The scan restarts cleanly after release.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : ROWS x COLS matrix keypad scanner with per-key debounce
//                  and a press/release event FIFO (valid/ready).
// Revision       : 1.0
// ============================================================================
module keypad_scanner #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int DEBOUNCE  = 3,
  parameter int EVT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [ROWS-1:0]               row_out,
  input  logic [COLS-1:0]               col_in,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_release,
  output logic [ROWS*COLS-1:0]          pressed,
  output logic                          overflow
);
  localparam int c_keys = ROWS * COLS;
  localparam int c_kw   = $clog2(c_keys);
  localparam int c_rw   = $clog2(ROWS);
  localparam int c_cw   = $clog2(COLS);
  localparam int c_dw   = $clog2(SCAN_DIV);
  localparam int c_bw   = $clog2(DEBOUNCE + 1);
  localparam int c_aw   = $clog2(EVT_DEPTH);
  localparam int c_nw   = $clog2(EVT_DEPTH + 1);
  localparam int c_ew   = c_kw + 1;

  localparam logic [c_dw-1:0] c_dwell_last = c_dw'(SCAN_DIV - 1);
  localparam logic [c_dw-1:0] c_cols       = c_dw'(COLS);
  localparam logic [c_rw-1:0] c_row_last   = c_rw'(ROWS - 1);
  localparam logic [c_bw-1:0] c_deb_last   = c_bw'(DEBOUNCE - 1);
  localparam logic [c_nw-1:0] c_depth      = c_nw'(EVT_DEPTH);

  logic [c_dw-1:0]   dwell_q, dwell_d;
  logic [c_rw-1:0]   row_q, row_d;
  logic [ROWS-1:0]   row_oh_q, row_oh_d;
  logic [COLS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [COLS-1:0]   cap_cols_q, cap_cols_d;
  logic [c_rw-1:0]   cap_row_q, cap_row_d;
  logic [c_bw-1:0]   cnt_q [c_keys];
  logic [c_bw-1:0]   cnt_d [c_keys];
  logic [c_keys-1:0] pressed_q, pressed_d;
  logic [c_ew-1:0]   mem_q [EVT_DEPTH];
  logic [c_ew-1:0]   mem_d [EVT_DEPTH];
  logic [c_aw-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [c_nw-1:0]   count_q, count_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;

  logic              w_wrap, w_eval, w_raw, w_push, w_pop, w_full, w_wr;
  logic [c_cw-1:0]   w_col;
  logic [c_kw-1:0]   w_key;
  logic [c_ew-1:0]   w_evt, w_head;

  // Row strobe, dwell timing, column synchroniser and end-of-dwell capture
  always_comb begin
    w_wrap     = (dwell_q == c_dwell_last);
    dwell_d    = w_wrap ? '0 : dwell_q + c_dw'(1);
    row_d      = row_q;
    row_oh_d   = row_oh_q;
    cap_cols_d = cap_cols_q;
    cap_row_d  = cap_row_q;
    sync1_d    = col_in;
    sync2_d    = sync1_q;
    if (w_wrap) begin
      row_d      = (row_q == c_row_last) ? '0 : row_q + c_rw'(1);
      row_oh_d   = {row_oh_q[ROWS-2:0], row_oh_q[ROWS-1]};
      cap_cols_d = sync2_q;
      cap_row_d  = row_q;
    end
  end

  // One captured key evaluated per cycle in the first COLS cycles of a dwell
  always_comb begin
    w_eval    = (dwell_q < c_cols);
    w_col     = dwell_q[c_cw-1:0];
    w_key     = c_kw'(int'(cap_row_q) * COLS + int'(w_col));
    w_raw     = cap_cols_q[w_col];
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    w_push    = 1'b0;
    w_evt     = '0;
    if (w_eval) begin
      if (w_raw == pressed_q[w_key]) begin
        cnt_d[w_key] = '0;
      end else if (cnt_q[w_key] == c_deb_last) begin
        pressed_d[w_key] = w_raw;
        cnt_d[w_key]     = '0;
        w_push           = 1'b1;
        w_evt            = {w_key, ~w_raw};
      end else begin
        cnt_d[w_key] = cnt_q[w_key] + c_bw'(1);
      end
    end
  end

  // Event FIFO: a push on a full FIFO is accepted only if a pop frees a slot
  always_comb begin
    w_pop      = valid_q && key_ready;
    w_full     = (count_q == c_depth);
    w_wr       = w_push && (!w_full || w_pop);
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    overflow_d = overflow_q | (w_push && w_full && !w_pop);
    if (w_wr) begin
      mem_d[wr_q] = w_evt;
      wr_d        = wr_q + c_aw'(1);
    end
    if (w_pop) begin
      rd_d = rd_q + c_aw'(1);
    end
    if (w_wr && !w_pop) begin
      count_d = count_q + c_nw'(1);
    end else if (!w_wr && w_pop) begin
      count_d = count_q - c_nw'(1);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q    <= '0;
      row_q      <= '0;
      row_oh_q   <= {{(ROWS-1){1'b0}}, 1'b1};
      sync1_q    <= '0;
      sync2_q    <= '0;
      cap_cols_q <= '0;
      cap_row_q  <= '0;
      pressed_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < c_keys; i++) cnt_q[i] <= '0;
      for (int i = 0; i < EVT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      row_oh_q   <= row_oh_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cap_cols_q <= cap_cols_d;
      cap_row_q  <= cap_row_d;
      pressed_q  <= pressed_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < c_keys; i++) cnt_q[i] <= cnt_d[i];
      for (int i = 0; i < EVT_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign w_head      = mem_q[rd_q];
  assign row_out     = row_oh_q;
  assign key_valid   = valid_q;
  assign key_code    = w_head[c_ew-1:1];
  assign key_release = w_head[0];
  assign pressed     = pressed_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed vectors and a randomized keypad run scored
//                     against a scan-level debounce model.
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, EVT_DEPTH = 4;
  localparam int KEYS = ROWS * COLS;
  localparam int SCAN = ROWS * SCAN_DIV;
  localparam int NSCAN = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_in;
  logic            key_valid, key_ready, key_release, overflow;
  logic [3:0]      key_code;
  logic [KEYS-1:0] pressed;

  logic [KEYS-1:0] held, rkeys, flip, mpressed;
  int              mcnt [KEYS];
  logic [4:0]      exp_q [$];
  bit              mon_en;
  int              cyc, checks, errors;

  typedef struct {
    int              cyc;
    logic [ROWS-1:0] row;
    logic            valid;
    logic [KEYS-1:0] pressed;
  } vec_t;
  vec_t vecs [10];

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                   .DEBOUNCE(DEBOUNCE), .EVT_DEPTH(EVT_DEPTH)) dut (
    .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_release(key_release), .pressed(pressed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key shorts its row strobe onto its column
  function automatic logic [COLS-1:0] sense(input logic [ROWS-1:0] rows, input logic [KEYS-1:0] keys);
    logic [COLS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rows[r] && keys[r*COLS+c]) v[c] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_pop();
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got code %0d release %0b, expected no event (cycle %0d)",
               key_code, key_release, cyc);
    end else begin
      e = exp_q.pop_front();
      check("rnd_evt_code", 32'(key_code), 32'(e[4:1]));
      check("rnd_evt_release", 32'(key_release), 32'(e[0]));
    end
  endtask

  task automatic set_keys(input logic [KEYS-1:0] k);
    held   = k;
    col_in = sense(row_out, held);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    col_in = sense(row_out, held);
    if (mon_en && key_valid && key_ready) monitor_pop();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    held   = '0;
    col_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  // Scan-level reference: one sample per key per scan, in row-major order
  task automatic model_scan(input logic [KEYS-1:0] keys);
    for (int k = 0; k < KEYS; k++) begin
      if (keys[k] == mpressed[k]) begin
        mcnt[k] = 0;
      end else begin
        mcnt[k]++;
        if (mcnt[k] == DEBOUNCE) begin
          mpressed[k] = keys[k];
          mcnt[k] = 0;
          exp_q.push_back({4'(k), ~keys[k]});
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; held = '0; col_in = '0; key_ready = 1'b1; mon_en = 1'b0;
    cyc = 0; checks = 0; errors = 0;

    vecs[0] = '{0,   4'b0001, 1'b0, 16'h0};
    vecs[1] = '{7,   4'b0001, 1'b0, 16'h0};
    vecs[2] = '{8,   4'b0010, 1'b0, 16'h0};
    vecs[3] = '{15,  4'b0010, 1'b0, 16'h0};
    vecs[4] = '{16,  4'b0100, 1'b0, 16'h0};
    vecs[5] = '{24,  4'b1000, 1'b0, 16'h0};
    vecs[6] = '{31,  4'b1000, 1'b0, 16'h0};
    vecs[7] = '{32,  4'b0001, 1'b0, 16'h0};
    vecs[8] = '{40,  4'b0010, 1'b0, 16'h0};
    vecs[9] = '{100, 4'b0001, 1'b0, 16'h0};

    // Free-running scan from reset
    do_reset();
    check("reset_code", 32'(key_code), 0);
    check("reset_release", 32'(key_release), 0);
    check("reset_overflow", 32'(overflow), 0);
    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].cyc);
      check("scan_row_out", 32'(row_out), 32'(vecs[i].row));
      check("scan_valid", 32'(key_valid), 32'(vecs[i].valid));
      check("scan_pressed", 32'(pressed), 32'(vecs[i].pressed));
    end

    // Key 6 press after third row-1 capture, then release
    do_reset();
    key_ready = 1'b0;
    set_keys(16'h0040);
    run_to(82);
    check("k6_early_pressed", 32'(pressed), 0);
    check("k6_early_valid", 32'(key_valid), 0);
    run_to(83);
    check("k6_press_valid", 32'(key_valid), 1);
    check("k6_press_code", 32'(key_code), 6);
    check("k6_press_release", 32'(key_release), 0);
    check("k6_press_pressed", 32'(pressed), 32'h0040);
    pop_one();
    check("k6_popped_valid", 32'(key_valid), 0);
    set_keys(16'h0000);
    run_to(178);
    check("k6_rel_early", 32'(pressed), 32'h0040);
    run_to(179);
    check("k6_rel_valid", 32'(key_valid), 1);
    check("k6_rel_code", 32'(key_code), 6);
    check("k6_rel_release", 32'(key_release), 1);
    check("k6_rel_pressed", 32'(pressed), 0);

    // Bounce: closed 2 scans, open 1, then closed until the third in a row
    do_reset();
    key_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      run_to(n * SCAN);
      set_keys((n == 2) ? 16'h0000 : 16'h0040);
    end
    run_to(160);
    check("bounce_valid", 32'(key_valid), 0);
    check("bounce_pressed", 32'(pressed), 0);
    run_to(178);
    check("bounce_valid_late", 32'(key_valid), 0);
    run_to(179);
    check("bounce_final_valid", 32'(key_valid), 1);
    check("bounce_final_code", 32'(key_code), 6);

    // Two keys on row 2 queue in ascending column order
    do_reset();
    key_ready = 1'b0;
    set_keys(16'h0900);
    run_to(89);
    check("two_first_valid", 32'(key_valid), 1);
    check("two_first_code", 32'(key_code), 8);
    run_to(96);
    check("two_hold_code", 32'(key_code), 8);
    check("two_pressed", 32'(pressed), 32'h0900);
    pop_one();
    check("two_second_valid", 32'(key_valid), 1);
    check("two_second_code", 32'(key_code), 11);
    check("two_second_release", 32'(key_release), 0);
    pop_one();
    check("two_empty", 32'(key_valid), 0);

    // Overflow: five presses into a four-deep FIFO with no consumer
    do_reset();
    key_ready = 1'b0;
    set_keys(16'h001F);
    run_to(73);
    check("ovf_first_code", 32'(key_code), 0);
    run_to(80);
    check("ovf_full_no_drop", 32'(overflow), 0);
    run_to(81);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_pressed", 32'(pressed), 32'h001F);
    check("ovf_head_steady", 32'(key_code), 0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_valid", 32'(key_valid), 1);
      check("ovf_pop_code", 32'(key_code), 32'(i));
      pop_one();
    end
    check("ovf_drained", 32'(key_valid), 0);
    check("ovf_still_set", 32'(overflow), 1);

    // Full FIFO with simultaneous push and pop keeps both events
    do_reset();
    key_ready = 1'b0;
    set_keys(16'h001F);
    run_to(80);
    pop_one();
    check("fullpp_overflow", 32'(overflow), 0);
    for (int i = 1; i < 5; i++) begin
      check("fullpp_code", 32'(key_code), 32'(i));
      pop_one();
    end
    check("fullpp_empty", 32'(key_valid), 0);

    // Asynchronous reset in the middle of a dwell
    do_reset();
    key_ready = 1'b0;
    set_keys(16'h005F);
    run_to(90);
    check("arst_pre_pressed", 32'(pressed), 32'h005F);
    check("arst_pre_overflow", 32'(overflow), 1);
    check("arst_pre_valid", 32'(key_valid), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(key_valid), 0);
    check("arst_pressed", 32'(pressed), 0);
    check("arst_row_out", 32'(row_out), 1);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_code", 32'(key_code), 0);
    held = '0;
    col_in = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    run_to(8);
    check("arst_restart_row", 32'(row_out), 32'h2);
    run_to(40);
    check("arst_restart_valid", 32'(key_valid), 0);
    check("arst_restart_pressed", 32'(pressed), 0);

    // Randomized keypad activity, keys changing only at scan boundaries
    do_reset();
    key_ready = 1'b1;
    mpressed = '0;
    rkeys = '0;
    for (int k = 0; k < KEYS; k++) mcnt[k] = 0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int n = 0; n < NSCAN; n++) begin
      run_to(n * SCAN);
      flip = '0;
      for (int k = 0; k < KEYS; k++) if ($urandom_range(7) == 0) flip[k] = 1'b1;
      rkeys = rkeys ^ flip;
      set_keys(rkeys);
      run_to(n * SCAN + 4);
      if (n > 0) check("rnd_pressed", 32'(pressed), 32'(mpressed));
      model_scan(rkeys);
    end
    run_to(NSCAN * SCAN + 5);
    mon_en = 1'b0;
    check("rnd_final_pressed", 32'(pressed), 32'(mpressed));
    check("rnd_events_left", 32'(exp_q.size()), 0);
    check("rnd_overflow", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
